// File: rtl/approx_mul_pkg.sv
`default_nettype none
// ============================================================================
// approx_mul_pkg
// Shared widths, mode encodings and pipeline occupancy states.
// Revision: 1.0
// ============================================================================
package approx_mul_pkg;

    localparam int OPW          = 8;
    localparam int PRODW        = 16;
    localparam int DEFAULT_NREQ = 4;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage
`default_nettype wire

// File: rtl/approx_mul8_core.sv
`default_nettype none
// ============================================================================
// approx_mul8_core
// Combinational 8x8 unsigned multiplier, approximate or exact by mode.
// Revision: 1.0
// ============================================================================
module approx_mul8_core
    import approx_mul_pkg::*;
(
    input  logic [OPW-1:0]   x,
    input  logic [OPW-1:0]   y,
    input  logic             mode,
    output logic [PRODW-1:0] z
);

    logic [PRODW-1:0] w_partial;
    logic [PRODW-1:0] w_approx;
    logic [PRODW-1:0] w_exact;

    // x[0] is dropped; x[1] only contributes through its product with y[7].
    assign w_partial = PRODW'(y) * PRODW'(x[OPW-1:2]);
    assign w_approx  = (w_partial << 2) + (PRODW'(x[1] & y[OPW-1]) << 8);
    assign w_exact   = PRODW'(x) * PRODW'(y);
    assign z         = (mode == MODE_APPROX) ? w_approx : w_exact;

endmodule
`default_nettype wire

// File: rtl/approx_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// approx_mul_share_ctrl
// Round-robin sharing of one multiplier core behind a two-stage pipeline.
// Revision: 1.0
// ============================================================================
module approx_mul_share_ctrl
    import approx_mul_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_x,
    input  logic [OPW*NREQ-1:0] req_y,
    input  logic                approx_en,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [PRODW-1:0]    res_z,
    output logic [IDW-1:0]      res_id,
    output logic                busy
);

    logic             r_s1_valid;
    logic [OPW-1:0]   r_s1_x;
    logic [OPW-1:0]   r_s1_y;
    logic [IDW-1:0]   r_s1_id;
    logic             r_s1_mode;
    logic             r_s2_valid;
    logic [PRODW-1:0] r_s2_z;
    logic [IDW-1:0]   r_s2_id;
    logic [IDW-1:0]   r_ptr;
    pipe_state_t      r_state;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_found;
    logic             w_grant;
    logic [IDW:0]     w_cand;
    logic [IDW-1:0]   w_gid;
    logic [IDW-1:0]   w_ptr_next;
    logic [PRODW-1:0] w_core_z;
    logic             w_s1_valid_next;
    logic             w_s2_valid_next;
    pipe_state_t      w_state_next;

    assign w_adv2 = !r_s2_valid || res_ready;
    assign w_adv1 = !r_s1_valid || w_adv2;

    // Search from the pointer upward, wrapping at NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_cand >= (IDW+1)'(NREQ))
                w_cand = w_cand - (IDW+1)'(NREQ);
            if (!w_found && req_valid[w_cand[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gid   = w_cand[IDW-1:0];
            end
        end
    end

    assign w_grant    = w_found && w_adv1 && !rst;
    assign w_ptr_next = (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + IDW'(1);

    always_comb begin
        req_ready        = '0;
        req_ready[w_gid] = w_grant;
    end

    approx_mul8_core u_core (
        .x    (r_s1_x),
        .y    (r_s1_y),
        .mode (r_s1_mode),
        .z    (w_core_z)
    );

    assign w_s2_valid_next = w_adv2 ? r_s1_valid : r_s2_valid;
    assign w_s1_valid_next = w_adv1 ? w_grant : r_s1_valid;

    always_comb begin
        case ({w_s1_valid_next, w_s2_valid_next})
            2'b00:   w_state_next = ST_EMPTY;
            2'b11:   w_state_next = ST_FULL;
            default: w_state_next = ST_ONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_id    <= '0;
            r_s1_mode  <= MODE_EXACT;
            r_s2_valid <= 1'b0;
            r_s2_z     <= '0;
            r_s2_id    <= '0;
            r_ptr      <= '0;
            r_state    <= ST_EMPTY;
        end else begin
            r_s1_valid <= w_s1_valid_next;
            r_s2_valid <= w_s2_valid_next;
            r_state    <= w_state_next;
            if (w_adv2 && r_s1_valid) begin
                r_s2_z  <= w_core_z;
                r_s2_id <= r_s1_id;
            end
            if (w_grant) begin
                r_s1_x    <= req_x[w_gid*OPW +: OPW];
                r_s1_y    <= req_y[w_gid*OPW +: OPW];
                r_s1_id   <= w_gid;
                r_s1_mode <= approx_en ? MODE_APPROX : MODE_EXACT;
                r_ptr     <= w_ptr_next;
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_z     = r_s2_z;
    assign res_id    = r_s2_id;
    assign busy      = (r_state != ST_EMPTY);

endmodule
`default_nettype wire

// File: tb/tb_approx_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// tb_approx_mul_share_ctrl
// Scoreboard bench: arbitration model, product model and scenario tasks.
// Revision: 1.0
// ============================================================================
module tb_approx_mul_share_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_x;
    logic [8*NREQ-1:0] req_y;
    logic              approx_en;
    logic              res_valid;
    logic              res_ready;
    logic [15:0]       res_z;
    logic [IDW-1:0]    res_id;
    logic              busy;

    always #5 clk = ~clk;

    approx_mul_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .approx_en (approx_en),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_z     (res_z),
        .res_id    (res_id),
        .busy      (busy)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_s1, m_s2;
    int   m_ptr;

    function automatic logic [15:0] model_mul(logic [7:0] x, logic [7:0] y, logic approx);
        int unsigned r;
        if (approx) begin
            r = (int'(y) * int'(x >> 2)) * 4;
            if (x[1] && y[7]) r = r + 256;
        end else begin
            r = int'(x) * int'(y);
        end
        return r[15:0];
    endfunction

    // Cycle model: predicts grants, occupancy and the result stream.
    always @(negedge clk) begin
        bit          adv1, adv2, g_any;
        int          g;
        logic [NREQ-1:0] exp_ready;
        exp_t        e;
        if (rst) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            m_ptr = 0;
            sb.delete();
        end else begin
            adv2 = !m_s2 || res_ready;
            adv1 = !m_s1 || adv2;
            exp_ready = '0;
            g_any = 1'b0;
            g = 0;
            if (adv1) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!g_any && req_valid[(m_ptr + k) % NREQ]) begin
                        g_any = 1'b1;
                        g = (m_ptr + k) % NREQ;
                    end
                end
            end
            if (g_any) exp_ready[g] = 1'b1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL mon_req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
            end
            checks++;
            if (busy !== (m_s1 || m_s2)) begin
                errors++;
                $display("FAIL mon_busy: got %b expected %b at %0t", busy, (m_s1 || m_s2), $time);
            end
            checks++;
            if (res_valid !== m_s2) begin
                errors++;
                $display("FAIL mon_res_valid: got %b expected %b at %0t", res_valid, m_s2, $time);
            end
            if (res_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mon_unexpected_result: got id=%0d z=%h expected none at %0t", res_id, res_z, $time);
                end else begin
                    if (res_z !== sb[0].z || res_id !== sb[0].id) begin
                        errors++;
                        $display("FAIL mon_result: got id=%0d z=%h expected id=%0d z=%h at %0t",
                                 res_id, res_z, sb[0].id, sb[0].z, $time);
                    end
                    if (res_ready) void'(sb.pop_front());
                end
            end
            if (g_any) begin
                e.id = IDW'(g);
                e.z  = model_mul(req_x[8*g +: 8], req_y[8*g +: 8], approx_en);
                sb.push_back(e);
                m_ptr = (g + 1) % NREQ;
            end
            m_s2 = adv2 ? m_s1 : m_s2;
            m_s1 = adv1 ? g_any : m_s1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && res_valid === 1'b0 && busy === 1'b0) break;
        end
        checks++;
        if (n == 50) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || res_z !== 16'h0 || res_id !== '0 || busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b z=%h id=%0d busy=%b rdy=%b expected all zero",
                     res_valid, res_z, res_id, busy, req_ready);
        end
        step();
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic do_single(logic [7:0] x, logic [7:0] y, logic mode, logic [15:0] expz);
        step();
        req_x[7:0] = x;
        req_y[7:0] = y;
        approx_en = mode;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        approx_en = ~mode;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got res_valid=%b expected 0", res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_z !== expz || res_id !== '0) begin
            errors++;
            $display("FAIL single_result: got v=%b z=%h id=%0d expected v=1 z=%h id=0",
                     res_valid, res_z, res_id, expz);
        end
        wait_drain();
    endtask

    task automatic test_single();
        do_single(8'hFF, 8'hFF, 1'b1, 16'hFC04);
        do_single(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        do_single(8'h03, 8'h80, 1'b1, 16'h0100);
        do_single(8'h03, 8'h80, 1'b0, 16'h0180);
        do_single(8'h01, 8'hFF, 1'b1, 16'h0000);
    endtask

    task automatic test_round_robin();
        apply_reset();
        req_x = $urandom();
        req_y = $urandom();
        approx_en = 1'($urandom_range(0, 1));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, 4'(1 << (k % 4)));
            end
            step();
            req_x = $urandom();
            req_y = $urandom();
            approx_en = 1'($urandom_range(0, 1));
        end
        req_valid = '0;
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        step();
        res_ready = 1'b0;
        req_x = $urandom();
        req_y = $urandom();
        req_x[7:0] = 8'h55;
        req_y[7:0] = 8'h3C;
        approx_en = 1'b1;
        held = model_mul(8'h55, 8'h3C, 1'b1);
        req_valid = 4'b1111;
        step();
        approx_en = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== '0 || res_valid !== 1'b1 || res_z !== held || res_id !== 2'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b z=%h id=%0d busy=%b expected rdy=0000 v=1 z=%h id=0 busy=1",
                         k, req_ready, res_valid, res_z, res_id, busy, held);
            end
            step();
        end
        req_valid = '0;
        res_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_wrap();
        apply_reset();
        req_x = $urandom();
        req_y = $urandom();
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_first: got %b expected 0100", req_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_around: got %b expected 0100", req_ready);
        end
        step();
        req_valid = 4'b1100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_ptr3: got %b expected 1000", req_ready);
        end
        step();
        req_valid = '0;
        wait_drain();
    endtask

    task automatic test_reset_full();
        step();
        res_ready = 1'b0;
        req_x = $urandom();
        req_y = $urandom();
        req_valid = 4'b1111;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL rst_full_flush: got v=%b busy=%b rdy=%b expected 0 0 0000", res_valid, busy, req_ready);
        end
        step();
        rst = 1'b0;
        res_ready = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_grant: got rdy=%b v=%b expected rdy=0010 v=0", req_ready, res_valid);
        end
        step();
        req_valid = '0;
        wait_drain();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b1111;
        req_x = '0;
        req_y = '0;
        approx_en = 1'b0;
        res_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
